// File: rtl/addsub_rr_sequencer.sv
// Round-robin sequencer sharing one combinational add/sub datapath between two requesters.
// Each operation runs accept -> execute -> respond, with a saturating overflow counter.
module addsub_rr_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_mode,
  input  logic [WIDTH-1:0] au_result,
  input  logic             au_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_v,
  output logic [7:0]       ovf_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] au_a_q, au_a_d;
  logic [WIDTH-1:0] au_b_q, au_b_d;
  logic             au_mode_q, au_mode_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_v_q, rsp_v_d;
  logic [7:0]       ovf_count_q, ovf_count_d;

  logic grant;
  logic accept;

  // Arbitration: a lone requester always wins; a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    // rst_n gating keeps both readies low for the whole reset interval.
    accept     = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    au_a_d       = au_a_q;
    au_b_d       = au_b_q;
    au_mode_d    = au_mode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_v_d      = rsp_v_q;
    ovf_count_d  = ovf_count_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          au_a_d       = grant ? req1_a    : req0_a;
          au_b_d       = grant ? req1_b    : req0_b;
          au_mode_d    = grant ? req1_mode : req0_mode;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = StExec;
        end
      end
      StExec: begin
        // Overflow comes from the datapath as-is; clamp direction follows operand A's sign.
        if (SAT_EN && au_v) begin
          rsp_result_d = au_a_q[WIDTH-1] ? SatNeg : SatPos;
        end else begin
          rsp_result_d = au_result;
        end
        rsp_v_d     = au_v;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        if (au_v && (ovf_count_q != 8'hFF)) begin
          ovf_count_d = ovf_count_q + 8'd1;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      au_a_q       <= '0;
      au_b_q       <= '0;
      au_mode_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_v_q      <= 1'b0;
      ovf_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      au_a_q       <= au_a_d;
      au_b_q       <= au_b_d;
      au_mode_q    <= au_mode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_v_q      <= rsp_v_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign au_a       = au_a_q;
  assign au_b       = au_b_q;
  assign au_mode    = au_mode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_v      = rsp_v_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_addsub_rr_sequencer.sv
// Bench for addsub_rr_sequencer: wrapped (SAT_EN=0) and clamping (SAT_EN=1) instances share stimulus,
// each with its own datapath model; responses are checked against a scoreboard queue.
module tb_addsub_rr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid, req0_mode, req1_mode, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       req0_ready_s0, req1_ready_s0, au_mode_s0, au_v_s0, rsp_valid_s0, rsp_id_s0, rsp_v_s0;
  logic [7:0] au_a_s0, au_b_s0, au_result_s0, rsp_result_s0, ovf_count_s0;
  logic       req0_ready_s1, req1_ready_s1, au_mode_s1, au_v_s1, rsp_valid_s1, rsp_id_s1, rsp_v_s1;
  logic [7:0] au_a_s1, au_b_s1, au_result_s1, rsp_result_s1, ovf_count_s1;

  // Datapath model, including the 0x00 - 0x80 quirk (result 0x80, no overflow flag).
  function automatic logic [8:0] dp(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] r;
    logic       v;
    r = m ? (a - b) : (a + b);
    if (m) v = (a[7] != b[7]) && (r[7] != a[7]);
    else   v = (a[7] == b[7]) && (r[7] != a[7]);
    if (m && (a == 8'h00) && (b == 8'h80)) v = 1'b0;
    return {v, r};
  endfunction

  function automatic logic [7:0] exp_res(input logic [7:0] a, input logic [7:0] b, input logic m,
                                         input bit sat);
    logic [8:0] d;
    d = dp(a, b, m);
    if (sat && d[8]) return a[7] ? 8'h80 : 8'h7F;
    return d[7:0];
  endfunction

  assign {au_v_s0, au_result_s0} = dp(au_a_s0, au_b_s0, au_mode_s0);
  assign {au_v_s1, au_result_s1} = dp(au_a_s1, au_b_s1, au_mode_s1);

  addsub_rr_sequencer #(.WIDTH(8), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_s0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready_s0), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode),
    .au_a(au_a_s0), .au_b(au_b_s0), .au_mode(au_mode_s0), .au_result(au_result_s0),
    .au_v(au_v_s0),
    .rsp_valid(rsp_valid_s0), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s0),
    .rsp_result(rsp_result_s0), .rsp_v(rsp_v_s0), .ovf_count(ovf_count_s0)
  );

  addsub_rr_sequencer #(.WIDTH(8), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_s1), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready_s1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode),
    .au_a(au_a_s1), .au_b(au_b_s1), .au_mode(au_mode_s1), .au_result(au_result_s1),
    .au_v(au_v_s1),
    .rsp_valid(rsp_valid_s1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s1),
    .rsp_result(rsp_result_s1), .rsp_v(rsp_v_s1), .ovf_count(ovf_count_s1)
  );

  typedef struct {
    logic       id;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       v;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       v;
  } vec_t;

  exp_t sb[$];
  logic grant_log[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic id, input logic [7:0] a, input logic [7:0] b,
                                  input logic m);
    logic [8:0] d;
    d = dp(a, b, m);
    return '{id: id, r0: exp_res(a, b, m, 1'b0), r1: exp_res(a, b, m, 1'b1), v: d[8]};
  endfunction

  // Response monitor: pops on each handshake, checks stability while stalled.
  logic       hold_pend = 1'b0;
  logic [9:0] hold_val  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      if (req0_ready_s0 || req1_ready_s0) chk("ready_onehot", req0_ready_s0 & req1_ready_s0, 0);
      if (hold_pend) begin
        chk("rsp_hold_valid", rsp_valid_s0, 1);
        chk("rsp_hold_data", {rsp_id_s0, rsp_v_s0, rsp_result_s0}, hold_val);
      end
      hold_pend = rsp_valid_s0 && !rsp_ready;
      hold_val  = {rsp_id_s0, rsp_v_s0, rsp_result_s0};
      if (rsp_valid_s0 && rsp_ready) begin
        if (sb.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id_s0, e.id);
          chk("rsp_result_wrap", rsp_result_s0, e.r0);
          chk("rsp_v", rsp_v_s0, e.v);
          chk("rsp_valid_sat", rsp_valid_s1, 1);
          chk("rsp_result_sat", rsp_result_s1, e.r1);
        end
      end
    end
  end

  // Drive one op, wait for ready (bounded), then check the N+1 / N+2 response timing.
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic m,
                       input exp_t e, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready_s0 : req0_ready_s0) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      fail_now("req_ready_timeout");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec_no_rsp", rsp_valid_s0, 0);
    @(negedge clk);
    chk("lat_rsp_valid", rsp_valid_s0, 1);
    tick();
  endtask

  vec_t tbl[10];

  initial begin
    int   waits;
    int   cnt;
    bit   got;
    exp_t e;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 8'h08, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b1};
    tbl[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1};
    tbl[3] = '{8'h00, 8'h80, 1'b1, 8'h80, 8'h80, 1'b0};
    tbl[4] = '{8'h10, 8'h20, 1'b1, 8'hF0, 8'hF0, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1};
    tbl[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 8'h7F, 1'b1};
    tbl[7] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 8'h80, 1'b0};
    tbl[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 8'h7F, 1'b1};

    // Reset with both requesters asserting.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_mode = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req0_ready", req0_ready_s0, 0);
      chk("rst_req1_ready", req1_ready_s0, 0);
    end
    chk("rst_outs_s0", {au_a_s0, au_b_s0, au_mode_s0, rsp_valid_s0, rsp_id_s0, rsp_result_s0,
                        rsp_v_s0}, 0);
    chk("rst_ovf_s0", ovf_count_s0, 0);
    chk("rst_outs_s1", {rsp_valid_s1, rsp_result_s1, ovf_count_s1}, 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Both requesters valid for four ops: grants must alternate starting at 0.
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h05; req1_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      @(negedge clk);
      if (req0_ready_s0) begin
        sb.push_back(mk_exp(1'b0, req0_a, req0_b, req0_mode)); grant_log.push_back(1'b0); cnt++;
      end else if (req1_ready_s0) begin
        sb.push_back(mk_exp(1'b1, req1_a, req1_b, req1_mode)); grant_log.push_back(1'b1); cnt++;
      end
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_grant_order", grant_log[i], i % 2);
    tick();

    // Table vectors, alternating requesters, issued back to back.
    for (int i = 0; i < 10; i++) begin
      e = '{id: 1'(i % 2), r0: tbl[i].r0, r1: tbl[i].r1, v: tbl[i].v};
      issue(1'(i % 2), tbl[i].a, tbl[i].b, tbl[i].m, e, waits);
      if (i > 0) chk("b2b_ready_wait", waits, 0);
    end
    chk("ovf_after_table_s0", ovf_count_s0, 5);
    chk("ovf_after_table_s1", ovf_count_s1, 5);

    // Drive the overflow counter up to and past saturation.
    for (int i = 0; i < 249; i++) issue(1'b0, 8'h7F, 8'h01, 1'b0, mk_exp(1'b0, 8'h7F, 8'h01, 1'b0), waits);
    chk("ovf_254", ovf_count_s0, 254);
    issue(1'b0, 8'h7F, 8'h01, 1'b0, mk_exp(1'b0, 8'h7F, 8'h01, 1'b0), waits);
    chk("ovf_255", ovf_count_s0, 255);
    issue(1'b0, 8'h80, 8'h01, 1'b1, mk_exp(1'b0, 8'h80, 8'h01, 1'b1), waits);
    chk("ovf_sat_256th", ovf_count_s0, 255);
    issue(1'b1, 8'h7F, 8'h01, 1'b0, mk_exp(1'b1, 8'h7F, 8'h01, 1'b0), waits);
    chk("ovf_sat_257th_s0", ovf_count_s0, 255);
    chk("ovf_sat_257th_s1", ovf_count_s1, 255);

    // Response stall with requester 1 waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req0_ready_s0;
    end
    if (!got) fail_now("stall_req0_ready");
    else sb.push_back(mk_exp(1'b0, 8'h12, 8'h34, 1'b0));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h50; req1_b = 8'h50; req1_mode = 1'b0;
    @(negedge clk);
    chk("stall_exec_req1_ready", req1_ready_s0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid_s0, 1);
      chk("stall_rsp_result", rsp_result_s0, 8'h46);
      chk("stall_req1_ready", req1_ready_s0, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req1_not_yet", req1_ready_s0, 0);
    @(negedge clk);
    chk("release_req1_ready", req1_ready_s0, 1);
    if (req1_ready_s0) sb.push_back(mk_exp(1'b1, 8'h50, 8'h50, 1'b0));
    tick();
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    tick();

    // Reset during EXEC: in-flight op from requester 0 is dropped, arbitration restarts.
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req0_ready_s0;
    end
    if (!got) fail_now("midrst_req0_ready");
    tick();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid_s0, 0);
    chk("midrst_ovf", ovf_count_s0, 0);
    chk("midrst_ready", {req0_ready_s0, req1_ready_s0}, 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h05; req1_mode = 1'b1;
    @(negedge clk);
    chk("postrst_req0_grant", req0_ready_s0, 1);
    chk("postrst_req1_grant", req1_ready_s0, 0);
    if (req0_ready_s0) sb.push_back(mk_exp(1'b0, 8'h02, 8'h03, 1'b0));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("postrst_exec_no_rsp", rsp_valid_s0, 0);
    @(negedge clk);
    chk("postrst_rsp_valid", rsp_valid_s0, 1);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
